// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared direction/state types and speed-to-step mapping for player movement
package player_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      IDLE   = 1'b0,
      MOVING = 1'b1
   } move_state_t;

   // Levels 2 and 3 both saturate at 4 px so a full tile stays a whole number of ticks.
   function automatic logic [2:0] speed_to_step(input logic [1:0] level);
      case (level)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - tile-aligned player movement driven by frame ticks and speed level
module player_move_ctrl
   import player_pkg::*;
#(
   parameter int TILE   = 32,
   parameter int INIT_X = 32,
   parameter int INIT_Y = 32,
   parameter int MIN_X  = 32,
   parameter int MAX_X  = 576,
   parameter int MIN_Y  = 32,
   parameter int MAX_Y  = 416
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [1:0]  speed_level,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_left,
   input  logic        key_right,
   input  logic [3:0]  blocked,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        moving,
   output logic [1:0]  facing,
   output logic        tileArrived
);

   localparam logic [11:0] TILE_W = 12'(TILE);

   move_state_t state_q, state_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic [5:0]  progress_q, progress_d;
   logic [2:0]  step_q, step_d;
   dir_t        facing_q, facing_d;
   logic        arrived_q, arrived_d;

   logic        req_valid, accept, do_move;
   dir_t        req_dir, move_dir;
   logic [2:0]  move_amt;
   logic [11:0] x_ext, y_ext;

   // Bounds are tested on the 12-bit extension so x+TILE never wraps.
   always_comb begin
      req_valid = key_up | key_down | key_left | key_right;
      if (key_up)         req_dir = UP;
      else if (key_down)  req_dir = DOWN;
      else if (key_left)  req_dir = LEFT;
      else                req_dir = RIGHT;
      x_ext = {1'b0, x_q};
      y_ext = {1'b0, y_q};
      case (req_dir)
         UP:      accept = !blocked[0] && (y_ext >= 12'(MIN_Y) + TILE_W);
         DOWN:    accept = !blocked[1] && (y_ext + TILE_W <= 12'(MAX_Y));
         LEFT:    accept = !blocked[2] && (x_ext >= 12'(MIN_X) + TILE_W);
         default: accept = !blocked[3] && (x_ext + TILE_W <= 12'(MAX_X));
      endcase
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      progress_d = progress_q;
      step_d     = step_q;
      facing_d   = facing_q;
      arrived_d  = 1'b0;
      do_move    = 1'b0;
      move_dir   = facing_q;
      move_amt   = step_q;
      if (startOfFrame) begin
         if (state_q == IDLE) begin
            if (req_valid) begin
               facing_d = req_dir;
               if (accept) begin
                  do_move    = 1'b1;
                  move_dir   = req_dir;
                  move_amt   = speed_to_step(speed_level);
                  step_d     = move_amt;
                  progress_d = {3'b000, move_amt};
                  state_d    = MOVING;
               end
            end
         end else begin
            do_move    = 1'b1;
            progress_d = progress_q + {3'b000, step_q};
            if (progress_d == 6'(TILE)) begin
               state_d    = IDLE;
               progress_d = '0;
               arrived_d  = 1'b1;
            end
         end
      end
      if (do_move) begin
         case (move_dir)
            UP:      y_d = y_q - {8'b0, move_amt};
            DOWN:    y_d = y_q + {8'b0, move_amt};
            LEFT:    x_d = x_q - {8'b0, move_amt};
            default: x_d = x_q + {8'b0, move_amt};
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         x_q        <= 11'(INIT_X);
         y_q        <= 11'(INIT_Y);
         progress_q <= '0;
         step_q     <= 3'd1;
         facing_q   <= DOWN;
         arrived_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         progress_q <= progress_d;
         step_q     <= step_d;
         facing_q   <= facing_d;
         arrived_q  <= arrived_d;
      end
   end

   assign topLeftX    = x_q;
   assign topLeftY    = y_q;
   assign moving      = (state_q == MOVING);
   assign facing      = facing_q;
   assign tileArrived = arrived_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed self-checking bench for player_move_ctrl
module tb_player_move_ctrl;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic [1:0]  speed_level = 2'd0;
   logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic [3:0]  blocked = 4'b0000;
   logic [10:0] topLeftX, topLeftY;
   logic        moving, tileArrived;
   logic [1:0]  facing;

   int tests = 0;
   int fails = 0;

   player_move_ctrl dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .speed_level(speed_level),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .blocked(blocked), .topLeftX(topLeftX), .topLeftY(topLeftY), .moving(moving),
      .facing(facing), .tileArrived(tileArrived)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // One frame tick; returns on the falling edge after the tick edge.
   task automatic tick();
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
   endtask

   task automatic apply_reset();
      {key_up, key_down, key_left, key_right} = 4'b0000;
      blocked = 4'b0000;
      @(negedge clk) resetN = 1'b0;
      @(negedge clk) resetN = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      tests++; if (topLeftX !== 11'd32) begin fails++; $display("FAIL reset_x: got %0d expected 32", topLeftX); end
      tests++; if (topLeftY !== 11'd32) begin fails++; $display("FAIL reset_y: got %0d expected 32", topLeftY); end
      tests++; if (moving !== 1'b0) begin fails++; $display("FAIL reset_moving: got %b expected 0", moving); end
      tests++; if (facing !== 2'd1) begin fails++; $display("FAIL reset_facing: got %0d expected 1", facing); end
      tests++; if (tileArrived !== 1'b0) begin fails++; $display("FAIL reset_arrived: got %b expected 0", tileArrived); end
      @(negedge clk) resetN = 1'b1;
   endtask

   task automatic test_right_slow();
      speed_level = 2'd0;
      key_right = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         tick();
         tests++; if (topLeftX !== 11'(32 + i)) begin fails++; $display("FAIL slow_x[%0d]: got %0d expected %0d", i, topLeftX, 32 + i); end
         tests++; if (tileArrived !== (i == 32)) begin fails++; $display("FAIL slow_arrived[%0d]: got %b expected %b", i, tileArrived, i == 32); end
         tests++; if (moving !== (i != 32)) begin fails++; $display("FAIL slow_moving[%0d]: got %b expected %b", i, moving, i != 32); end
      end
      key_right = 1'b0;
      for (int i = 34; i <= 64; i++) tick();
      tests++; if (topLeftX !== 11'd96) begin fails++; $display("FAIL slow_second_x: got %0d expected 96", topLeftX); end
      tests++; if (tileArrived !== 1'b1) begin fails++; $display("FAIL slow_second_arrived: got %b expected 1", tileArrived); end
   endtask

   task automatic test_down_fast();
      speed_level = 2'd2;
      key_down = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests++; if (topLeftY !== 11'(32 + 4 * i)) begin fails++; $display("FAIL fast_y[%0d]: got %0d expected %0d", i, topLeftY, 32 + 4 * i); end
         tests++; if (tileArrived !== (i == 8)) begin fails++; $display("FAIL fast_arrived[%0d]: got %b expected %b", i, tileArrived, i == 8); end
      end
      key_down = 1'b0;
      tests++; if (moving !== 1'b0) begin fails++; $display("FAIL fast_moving: got %b expected 0", moving); end
      tests++; if (topLeftX !== 11'd96) begin fails++; $display("FAIL fast_x_hold: got %0d expected 96", topLeftX); end
   endtask

   task automatic test_rejects();
      apply_reset();
      key_left = 1'b1;
      tick();
      key_left = 1'b0;
      tests++; if (topLeftX !== 11'd32) begin fails++; $display("FAIL minx_x: got %0d expected 32", topLeftX); end
      tests++; if (facing !== 2'd2) begin fails++; $display("FAIL minx_facing: got %0d expected 2", facing); end
      tests++; if (moving !== 1'b0) begin fails++; $display("FAIL minx_moving: got %b expected 0", moving); end
      speed_level = 2'd2;
      key_down = 1'b1;
      tick();
      key_down = 1'b0;
      for (int i = 2; i <= 8; i++) tick();
      tests++; if (topLeftY !== 11'd64) begin fails++; $display("FAIL setup_y: got %0d expected 64", topLeftY); end
      blocked = 4'b0001;
      key_up = 1'b1;
      tick();
      tests++; if (topLeftY !== 11'd64) begin fails++; $display("FAIL blocked_y: got %0d expected 64", topLeftY); end
      tests++; if (facing !== 2'd0) begin fails++; $display("FAIL blocked_facing: got %0d expected 0", facing); end
      tests++; if (moving !== 1'b0) begin fails++; $display("FAIL blocked_moving: got %b expected 0", moving); end
      blocked = 4'b1110;
      tick();
      key_up = 1'b0;
      blocked = 4'b0000;
      tests++; if (topLeftY !== 11'd60) begin fails++; $display("FAIL other_blocked_y: got %0d expected 60", topLeftY); end
      for (int i = 2; i <= 8; i++) tick();
      tests++; if (topLeftY !== 11'd32) begin fails++; $display("FAIL up_done_y: got %0d expected 32", topLeftY); end
   endtask

   task automatic test_speed_change();
      speed_level = 2'd0;
      key_right = 1'b1;
      tick();
      key_right = 1'b0;
      for (int i = 2; i <= 5; i++) tick();
      tests++; if (topLeftX !== 11'd37) begin fails++; $display("FAIL spd_x5: got %0d expected 37", topLeftX); end
      speed_level = 2'd2;
      for (int i = 6; i <= 32; i++) begin
         tick();
         tests++; if (topLeftX !== 11'(32 + i)) begin fails++; $display("FAIL spd_x[%0d]: got %0d expected %0d", i, topLeftX, 32 + i); end
         tests++; if (tileArrived !== (i == 32)) begin fails++; $display("FAIL spd_arrived[%0d]: got %b expected %b", i, tileArrived, i == 32); end
      end
      key_right = 1'b1;
      tick();
      key_right = 1'b0;
      tests++; if (topLeftX !== 11'd68) begin fails++; $display("FAIL spd_next_x: got %0d expected 68", topLeftX); end
      for (int i = 2; i <= 8; i++) tick();
      tests++; if (topLeftX !== 11'd96) begin fails++; $display("FAIL spd_next_done: got %0d expected 96", topLeftX); end
      tests++; if (tileArrived !== 1'b1) begin fails++; $display("FAIL spd_next_arrived: got %b expected 1", tileArrived); end
   endtask

   task automatic test_priority();
      speed_level = 2'd2;
      key_down = 1'b1;
      tick();
      key_down = 1'b0;
      for (int i = 2; i <= 8; i++) tick();
      {key_up, key_right} = 2'b11;
      tick();
      {key_up, key_right} = 2'b00;
      tests++; if (topLeftY !== 11'd60) begin fails++; $display("FAIL prio_y: got %0d expected 60", topLeftY); end
      tests++; if (topLeftX !== 11'd96) begin fails++; $display("FAIL prio_x: got %0d expected 96", topLeftX); end
      tests++; if (facing !== 2'd0) begin fails++; $display("FAIL prio_facing: got %0d expected 0", facing); end
      for (int i = 2; i <= 8; i++) tick();
      tests++; if (topLeftY !== 11'd32) begin fails++; $display("FAIL release_y: got %0d expected 32", topLeftY); end
      tests++; if (tileArrived !== 1'b1) begin fails++; $display("FAIL release_arrived: got %b expected 1", tileArrived); end
   endtask

   task automatic test_reset_mid_move();
      apply_reset();
      speed_level = 2'd0;
      key_right = 1'b1;
      for (int i = 1; i <= 13; i++) tick();
      key_right = 1'b0;
      tests++; if (topLeftX !== 11'd45) begin fails++; $display("FAIL mid_x: got %0d expected 45", topLeftX); end
      #2 resetN = 1'b0;
      #1;
      tests++; if (topLeftX !== 11'd32) begin fails++; $display("FAIL async_x: got %0d expected 32", topLeftX); end
      tests++; if (moving !== 1'b0) begin fails++; $display("FAIL async_moving: got %b expected 0", moving); end
      tests++; if (facing !== 2'd1) begin fails++; $display("FAIL async_facing: got %0d expected 1", facing); end
      #1 resetN = 1'b1;
      key_right = 1'b1;
      tick();
      key_right = 1'b0;
      tests++; if (topLeftX !== 11'd33) begin fails++; $display("FAIL post_rst_x: got %0d expected 33", topLeftX); end
      for (int i = 2; i <= 32; i++) tick();
      tests++; if (topLeftX !== 11'd64) begin fails++; $display("FAIL post_rst_done: got %0d expected 64", topLeftX); end
      tests++; if (tileArrived !== 1'b1) begin fails++; $display("FAIL post_rst_arrived: got %b expected 1", tileArrived); end
   endtask

   task automatic test_back_to_back();
      speed_level = 2'd0;
      key_down = 1'b1;
      @(negedge clk) startOfFrame = 1'b1;
      repeat (3) @(negedge clk);
      startOfFrame = 1'b0;
      key_down = 1'b0;
      tests++; if (topLeftY !== 11'd35) begin fails++; $display("FAIL b2b_y: got %0d expected 35", topLeftY); end
      tests++; if (moving !== 1'b1) begin fails++; $display("FAIL b2b_moving: got %b expected 1", moving); end
   endtask

   initial begin
      test_reset();
      test_right_slow();
      test_down_fast();
      test_rejects();
      test_speed_change();
      test_priority();
      test_reset_mid_move();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
